// File: rtl/rv32im_csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : rv32im_csr_access_unit
// Description : Read-modify-write sequencer for Zicsr instructions
//               (CSRRW/RS/RC/RWI/RSI/RCI). It sits between the execute stage
//               and rv32im_csr_regfile.
//
//               Flow: IDLE -> READ -> [WRITE] -> RESP -> IDLE.
//               A write is issued only when it is architecturally required.
//               The old CSR value is returned for writeback to rd.
//               Illegal accesses raise rsp_illegal_o and never write the
//               register file.
//
// Ports       : clk_i/rst_i      - clock, synchronous active-high reset
//               req_*            - decoded request (valid/ready handshake)
//               priv_mode_i      - current privilege level
//               csr_*            - register-file read/write strobes, address,
//                                  write data and combinational read data
//               rsp_*            - response to writeback (valid/ready handshake)
//
// Config      : `define CSR_ACCESS_PRIV_CHECK_EN to enable the privilege
//               check (addr[9:8] > priv_mode_i => illegal). When it is not
//               defined, priv_mode_i is ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module rv32im_csr_access_unit #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // request
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_funct3_i,
    input  logic [CSR_AW-1:0] req_csr_addr_i,
    input  logic [4:0]        req_rs1_idx_i,
    input  logic [XLEN-1:0]   req_rs1_val_i,
    input  logic [4:0]        req_rd_i,
    input  logic [1:0]        priv_mode_i,
    // register file
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic              csr_read_en_o,
    input  logic [XLEN-1:0]   csr_rdata_i,
    output logic              csr_write_en_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    // response
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [4:0]        rsp_rd_o,
    output logic [XLEN-1:0]   rsp_data_o,
    output logic              rsp_we_o,
    output logic              rsp_illegal_o
);

    // State encoding is fixed so it stays stable across tool versions.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // funct3[1:0] selects the operation; funct3[2] selects the immediate form.
    localparam logic [1:0] c_OP_BAD = 2'b00;
    localparam logic [1:0] c_OP_RW  = 2'b01;
    localparam logic [1:0] c_OP_RS  = 2'b10;
    localparam logic [1:0] c_OP_RC  = 2'b11;

    state_t            r_state;
    state_t            w_state_nxt;

    // Request fields latched at acceptance.
    logic [1:0]        r_op;
    logic [CSR_AW-1:0] r_addr;
    logic [XLEN-1:0]   r_operand;
    logic [4:0]        r_rd;
    logic              r_read_req;
    logic              r_write_req;
    logic              r_illegal;

    // Results of the READ cycle.
    logic [XLEN-1:0]   r_old;
    logic [XLEN-1:0]   r_new;

    // ------------------------------------------------------------------
    // Request decode (evaluated on the incoming request in IDLE)
    // ------------------------------------------------------------------
    logic              w_accept;
    logic [1:0]        w_op;
    logic              w_bad_funct3;
    logic [XLEN-1:0]   w_operand;
    logic              w_write_req;
    logic              w_read_req;
    logic              w_ro_bad;
    logic              w_priv_bad;
    logic              w_illegal;

    assign w_accept     = (r_state == ST_IDLE) && req_valid_i;
    assign w_op         = req_funct3_i[1:0];
    assign w_bad_funct3 = (w_op == c_OP_BAD);

    // Immediate forms use the rs1 field as a zero-extended 5-bit zimm.
    assign w_operand = req_funct3_i[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx_i}
                                       : req_rs1_val_i;

    // Set/clear with a zero source (x0 or zimm=0) must not write, so
    // read-only CSRs can still be read with CSRRS rd, csr, x0.
    assign w_write_req = (w_op == c_OP_RW) || (req_rs1_idx_i != 5'd0);

    // CSRRW/CSRRWI with rd=x0 must not read, to avoid read side effects.
    assign w_read_req  = !((w_op == c_OP_RW) && (req_rd_i == 5'd0));

    // addr[11:10] == 2'b11 marks a read-only CSR.
    assign w_ro_bad    = w_write_req && (req_csr_addr_i[11:10] == 2'b11);

`ifdef CSR_ACCESS_PRIV_CHECK_EN
    // addr[9:8] encodes the lowest privilege allowed to access the CSR.
    assign w_priv_bad  = (req_csr_addr_i[9:8] > priv_mode_i);
`else
    logic w_unused_priv;
    assign w_unused_priv = ^priv_mode_i;
    assign w_priv_bad    = 1'b0;
`endif

    assign w_illegal = w_bad_funct3 || w_ro_bad || w_priv_bad;

    // ------------------------------------------------------------------
    // Read-modify-write datapath (valid in READ)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_old_data;
    logic [XLEN-1:0] w_new_data;

    // A skipped read returns zero rather than whatever is on the bus.
    assign w_old_data = r_read_req ? csr_rdata_i : '0;

    always_comb begin
        w_new_data = r_operand;
        case (r_op)
            c_OP_RW: w_new_data = r_operand;
            c_OP_RS: w_new_data = w_old_data | r_operand;
            c_OP_RC: w_new_data = w_old_data & ~r_operand;
            default: w_new_data = r_operand;
        endcase
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_op        <= c_OP_BAD;
            r_addr      <= '0;
            r_operand   <= '0;
            r_rd        <= 5'd0;
            r_read_req  <= 1'b0;
            r_write_req <= 1'b0;
            r_illegal   <= 1'b0;
            r_old       <= '0;
            r_new       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op        <= w_op;
                r_addr      <= req_csr_addr_i;
                r_operand   <= w_operand;
                r_rd        <= req_rd_i;
                r_read_req  <= w_read_req;
                r_write_req <= w_write_req;
                r_illegal   <= w_illegal;
                // Cleared here because an illegal funct3 bypasses READ.
                r_old       <= '0;
                r_new       <= '0;
            end
            if (r_state == ST_READ) begin
                // An illegal access never returns CSR contents.
                r_old <= r_illegal ? '0 : w_old_data;
                r_new <= w_new_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    w_state_nxt = w_bad_funct3 ? ST_RESP : ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = (r_write_req && !r_illegal) ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from the state so that every output idles at zero
    // ------------------------------------------------------------------
    always_comb begin
        req_ready_o    = 1'b0;
        csr_addr_o     = '0;
        csr_read_en_o  = 1'b0;
        csr_write_en_o = 1'b0;
        csr_wdata_o    = '0;
        rsp_valid_o    = 1'b0;
        rsp_rd_o       = 5'd0;
        rsp_data_o     = '0;
        rsp_we_o       = 1'b0;
        rsp_illegal_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
            end
            ST_READ: begin
                csr_addr_o    = r_addr;
                csr_read_en_o = r_read_req;
            end
            ST_WRITE: begin
                csr_addr_o     = r_addr;
                csr_write_en_o = 1'b1;
                csr_wdata_o    = r_new;
            end
            ST_RESP: begin
                rsp_valid_o   = 1'b1;
                rsp_rd_o      = r_rd;
                rsp_data_o    = r_old;
                rsp_we_o      = !r_illegal && (r_rd != 5'd0);
                rsp_illegal_o = r_illegal;
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32im_csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32im_csr_access_unit
// Description : Self-checking bench for rv32im_csr_access_unit.
//               It contains a simple CSR array that acts as the register file.
//               A table of directed vectors is applied in a loop.
//               Hand-written sequences then cover stalls and reset in
//               mid-operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32im_csr_access_unit;

    localparam int XLEN   = 32;
    localparam int CSR_AW = 12;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [2:0]        req_funct3_i;
    logic [CSR_AW-1:0] req_csr_addr_i;
    logic [4:0]        req_rs1_idx_i;
    logic [XLEN-1:0]   req_rs1_val_i;
    logic [4:0]        req_rd_i;
    logic [1:0]        priv_mode_i;
    logic [CSR_AW-1:0] csr_addr_o;
    logic              csr_read_en_o;
    logic [XLEN-1:0]   csr_rdata_i;
    logic              csr_write_en_o;
    logic [XLEN-1:0]   csr_wdata_o;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [4:0]        rsp_rd_o;
    logic [XLEN-1:0]   rsp_data_o;
    logic              rsp_we_o;
    logic              rsp_illegal_o;

    always #5 clk_i = ~clk_i;

    rv32im_csr_access_unit #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_funct3_i   (req_funct3_i),
        .req_csr_addr_i (req_csr_addr_i),
        .req_rs1_idx_i  (req_rs1_idx_i),
        .req_rs1_val_i  (req_rs1_val_i),
        .req_rd_i       (req_rd_i),
        .priv_mode_i    (priv_mode_i),
        .csr_addr_o     (csr_addr_o),
        .csr_read_en_o  (csr_read_en_o),
        .csr_rdata_i    (csr_rdata_i),
        .csr_write_en_o (csr_write_en_o),
        .csr_wdata_o    (csr_wdata_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rd_o       (rsp_rd_o),
        .rsp_data_o     (rsp_data_o),
        .rsp_we_o       (rsp_we_o),
        .rsp_illegal_o  (rsp_illegal_o)
    );

    // CSR array standing in for the register file.
    // Reads are combinational.
    // The preload port lets the bench seed values.
    logic [XLEN-1:0]   csr_mem [0:4095];
    logic              pl_en;
    logic [CSR_AW-1:0] pl_addr;
    logic [XLEN-1:0]   pl_data;

    assign csr_rdata_i = csr_mem[csr_addr_o];

    always @(posedge clk_i) begin
        if (pl_en)
            csr_mem[pl_addr] <= pl_data;
        else if (csr_write_en_o)
            csr_mem[csr_addr_o] <= csr_wdata_o;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [31:0] val;
        logic [4:0]  rd;
        logic [1:0]  priv;
        logic [31:0] init;
        int          exp_rdc;
        int          exp_wrc;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_we;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk_i); #1;
        pl_en   = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                             input logic [31:0] val, input logic [4:0] rd, input logic [1:0] pv);
        req_funct3_i   = f3;
        req_csr_addr_i = a;
        req_rs1_idx_i  = idx;
        req_rs1_val_i  = val;
        req_rd_i       = rd;
        priv_mode_i    = pv;
        req_valid_i    = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int cyc, lat, rdc, wrc, both;
        logic [31:0] wd, d;
        logic we, ill;
        logic [4:0] rd;
        string s;
        preload(v.addr, v.init);
        chk($sformatf("v%0d_ready", n), {31'b0, req_ready_o}, 32'd1);
        drive_req(v.f3, v.addr, v.idx, v.val, v.rd, v.priv);
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        cyc = 1; lat = 0; rdc = 0; wrc = 0; both = 0; wd = '0;
        d = '0; we = 1'b0; ill = 1'b0; rd = 5'd0;
        while (cyc <= 20 && lat == 0) begin
            if (csr_read_en_o) rdc++;
            if (csr_write_en_o) begin
                wrc++;
                wd = csr_wdata_o;
            end
            if (csr_read_en_o && csr_write_en_o) both = 1;
            if (rsp_valid_o) begin
                lat = cyc;
                d = rsp_data_o; we = rsp_we_o; ill = rsp_illegal_o; rd = rsp_rd_o;
            end else begin
                @(posedge clk_i); #1;
                cyc++;
            end
        end
        s = $sformatf("v%0d", n);
        chk({s, "_latency"}, lat, v.exp_lat);
        chk({s, "_read_strobes"}, rdc, v.exp_rdc);
        chk({s, "_write_strobes"}, wrc, v.exp_wrc);
        chk({s, "_strobe_overlap"}, both, 0);
        if (v.exp_wrc != 0) chk({s, "_wdata"}, wd, v.exp_wdata);
        chk({s, "_rsp_data"}, d, v.exp_data);
        chk({s, "_rsp_we"}, {31'b0, we}, {31'b0, v.exp_we});
        chk({s, "_rsp_illegal"}, {31'b0, ill}, {31'b0, v.exp_ill});
        chk({s, "_rsp_rd"}, {27'b0, rd}, {27'b0, v.rd});
        @(posedge clk_i); #1;
        chk({s, "_back_idle"}, {31'b0, req_ready_o}, 32'd1);
        chk({s, "_csr_final"}, csr_mem[v.addr], (v.exp_wrc != 0) ? v.exp_wdata : v.init);
    endtask

    initial begin
        int cyc, wrc, stable_bad;
        logic [31:0] sd;

        rst_i = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        req_funct3_i = '0; req_csr_addr_i = '0; req_rs1_idx_i = '0;
        req_rs1_val_i = '0; req_rd_i = '0; priv_mode_i = 2'd3;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        //          f3      addr     idx    val            rd     pv     init           rdc wrc wdata          data           we    ill   lat
        vecs[0]  = '{3'b001, 12'h340, 5'd7,  32'hDEADBEEF, 5'd5,  2'd3, 32'h12345678, 1, 1, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0, 3};
        vecs[1]  = '{3'b010, 12'h304, 5'd0,  32'hFFFFFFFF, 5'd3,  2'd3, 32'h00000888, 1, 0, 32'h0,        32'h00000888, 1'b1, 1'b0, 2};
        vecs[2]  = '{3'b111, 12'h300, 5'd8,  32'hFFFFFFFF, 5'd1,  2'd3, 32'h00000188, 1, 1, 32'h00000180, 32'h00000188, 1'b1, 1'b0, 3};
        vecs[3]  = '{3'b001, 12'hF14, 5'd2,  32'h00001234, 5'd4,  2'd3, 32'h00000007, 1, 0, 32'h0,        32'h0,        1'b0, 1'b1, 2};
        vecs[4]  = '{3'b000, 12'h340, 5'd1,  32'h00000005, 5'd6,  2'd3, 32'h00000099, 0, 0, 32'h0,        32'h0,        1'b0, 1'b1, 1};
        vecs[5]  = '{3'b100, 12'h340, 5'd1,  32'h00000005, 5'd6,  2'd3, 32'h00000099, 0, 0, 32'h0,        32'h0,        1'b0, 1'b1, 1};
        vecs[6]  = '{3'b110, 12'h341, 5'h15, 32'h0,        5'd0,  2'd3, 32'h000000A0, 1, 1, 32'h000000B5, 32'h000000A0, 1'b0, 1'b0, 3};
        vecs[7]  = '{3'b011, 12'h342, 5'd9,  32'h0F0F0F0F, 5'd10, 2'd3, 32'hFFFF00FF, 1, 1, 32'hF0F000F0, 32'hFFFF00FF, 1'b1, 1'b0, 3};
        vecs[8]  = '{3'b101, 12'h343, 5'h1F, 32'h0,        5'd0,  2'd3, 32'h00000055, 0, 1, 32'h0000001F, 32'h0,        1'b0, 1'b0, 3};
        vecs[9]  = '{3'b010, 12'hC00, 5'd0,  32'h0,        5'd7,  2'd3, 32'h00000077, 1, 0, 32'h0,        32'h00000077, 1'b1, 1'b0, 2};
        vecs[10] = '{3'b010, 12'hC00, 5'd1,  32'h0,        5'd7,  2'd3, 32'h00000077, 1, 0, 32'h0,        32'h0,        1'b0, 1'b1, 2};
`ifdef CSR_ACCESS_PRIV_CHECK_EN
        vecs[11] = '{3'b010, 12'h300, 5'd0,  32'h0,        5'd2,  2'd0, 32'h00001800, 1, 0, 32'h0,        32'h0,        1'b0, 1'b1, 2};
`else
        vecs[11] = '{3'b010, 12'h300, 5'd0,  32'h0,        5'd2,  2'd0, 32'h00001800, 1, 0, 32'h0,        32'h00001800, 1'b1, 1'b0, 2};
`endif

        // Reset state
        @(posedge clk_i); @(posedge clk_i); #1;
        chk("reset_ready", {31'b0, req_ready_o}, 32'd1);
        chk("reset_strobes", {30'b0, csr_read_en_o, csr_write_en_o}, 32'd0);
        chk("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("reset_rsp_bus", rsp_data_o | {27'b0, rsp_rd_o} | {30'b0, rsp_we_o, rsp_illegal_o}, 32'd0);
        chk("reset_csr_bus", csr_wdata_o | {20'b0, csr_addr_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Response stall, then reset while in RESP
        preload(12'h340, 32'hAAAA5555);
        drive_req(3'b001, 12'h340, 5'd3, 32'h00001234, 5'd9, 2'd3);
        rsp_ready_i = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        cyc = 0;
        while (!rsp_valid_o && cyc < 10) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        chk("stall_reach_resp", {31'b0, rsp_valid_o}, 32'd1);
        chk("stall_rsp_data", rsp_data_o, 32'hAAAA5555);
        stable_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i); #1;
            if (!rsp_valid_o || rsp_data_o !== 32'hAAAA5555 || rsp_rd_o !== 5'd9 ||
                !rsp_we_o || rsp_illegal_o || csr_write_en_o || csr_read_en_o)
                stable_bad++;
        end
        chk("stall_outputs_stable", stable_bad, 0);
        chk("stall_csr_written_once", csr_mem[12'h340], 32'h00001234);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("stall_rst_ready", {31'b0, req_ready_o}, 32'd1);
        chk("stall_rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;

        // Reset during READ of a CSRRW drops the pending write
        preload(12'h340, 32'hCAFEF00D);
        drive_req(3'b001, 12'h340, 5'd4, 32'h11111111, 5'd5, 2'd3);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk("rstread_in_read", {31'b0, csr_read_en_o}, 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        wrc = 0;
        sd  = '0;
        for (int k = 0; k < 6; k++) begin
            if (csr_write_en_o) wrc++;
            if (rsp_valid_o) sd = sd + 1;
            @(posedge clk_i); #1;
        end
        chk("rstread_no_write", wrc, 0);
        chk("rstread_no_rsp", sd, 32'd0);
        chk("rstread_csr_unchanged", csr_mem[12'h340], 32'hCAFEF00D);
        chk("rstread_ready", {31'b0, req_ready_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
